// File: rtl/lut_table_loader_pkg.sv
// Shared sizing constants and FSM state type for the serial LUT table loader.
// The table geometry lives here so the top and the serializer agree on widths.
package lut_table_loader_pkg;

  localparam int TABLE_BITS = 256;
  localparam int BYTE_W     = 8;
  localparam int NUM_BYTES  = TABLE_BITS / BYTE_W;
  localparam int CNT_W      = $clog2(TABLE_BITS);
  localparam int IDX_W      = $clog2(BYTE_W);
  // Byte counter must be able to hold NUM_BYTES itself, not just NUM_BYTES-1.
  localparam int BCNT_W     = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lut_byte_serializer.sv
// One-byte shift buffer: takes a byte and emits it MSB first, one bit per clk.
// A new byte may be loaded while the last bit of the current one is going out.
module lut_byte_serializer
  import lut_table_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  output logic              can_accept,
  output logic              shift_en,
  output logic              bit_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);

  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              full_q, full_d;

  assign shift_en   = full_q;
  assign bit_out    = shreg_q[BYTE_W-1];
  assign can_accept = !full_q || (idx_q == LAST_IDX);

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    full_d  = full_q;
    if (clear) begin
      shreg_d = '0;
      idx_d   = '0;
      full_d  = 1'b0;
    end else if (load) begin
      shreg_d = load_data;
      idx_d   = '0;
      full_d  = 1'b1;
    end else if (full_q) begin
      shreg_d = shreg_q << 1;
      if (idx_q == LAST_IDX) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: rtl/lut_table_loader.sv
// Fills the serial-load LUT table from a byte stream: FSM plus bit/byte counters,
// with registered d/cs_n pins driven from the byte serializer.
module lut_table_loader
  import lut_table_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              lut_d,
  output logic              lut_cs_n,
  output logic              busy,
  output logic              table_valid
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              cs_n_q, cs_n_d;
  logic              d_q, d_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              ser_can_accept, ser_shift, ser_bit, accept;

  // Ready depends only on state and counters so the source never sees a loop through valid.
  assign byte_ready = (state_q == LOAD) && ser_can_accept &&
                      (byte_cnt_q < BCNT_W'(NUM_BYTES));
  assign accept     = byte_valid && byte_ready;

  lut_byte_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (abort),
    .load       (accept),
    .load_data  (byte_data),
    .can_accept (ser_can_accept),
    .shift_en   (ser_shift),
    .bit_out    (ser_bit)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    valid_d    = valid_q;
    cs_n_d     = 1'b1;
    d_d        = 1'b0;
    if (abort) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      valid_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = LOAD;
            valid_d    = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end
        end
        LOAD: begin
          if (accept) byte_cnt_d = byte_cnt_q + 1'b1;
          if (ser_shift) begin
            cs_n_d    = 1'b0;
            d_d       = ser_bit;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(TABLE_BITS - 1)) state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          valid_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      cs_n_q     <= 1'b1;
      d_q        <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      cs_n_q     <= cs_n_d;
      d_q        <= d_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign lut_cs_n    = cs_n_q;
  assign lut_d       = d_q;
  assign busy        = busy_q;
  assign table_valid = valid_q;

endmodule

// File: tb/tb_lut_table_loader.sv
// Bench for lut_table_loader: emulates the downstream LUT shift register and
// checks table contents, shift counts, stalls, abort, reset and start/abort races.
module tb_lut_table_loader;
  import lut_table_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready, lut_d, lut_cs_n, busy, table_valid;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  lut_table_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .lut_d       (lut_d),
    .lut_cs_n    (lut_cs_n),
    .busy        (busy),
    .table_valid (table_valid)
  );

  typedef struct {
    logic       rand_data;
    logic [7:0] first_byte;
    logic [7:0] step;
    int         stall_after;
    int         stall_len;
    logic       rand_stall;
    logic       start_mid;
    logic       extra_byte;
    int         abort_at;
    int         reset_at;
    int         exp_shifts;
  } vec_t;

  vec_t vecs[7];

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_pins(input string tag);
    check_output({tag, "_cs_n"}, lut_cs_n, 1'b1);
    check_output({tag, "_busy"}, busy, 1'b0);
    check_output({tag, "_ready"}, byte_ready, 1'b0);
  endtask

  // Runs one table load and checks the result against a plain bit-stream model.
  task automatic apply_stimulus(input int k, input vec_t v);
    logic [7:0]   bytes [32];
    logic [255:0] lut_m, exp_tab;
    int           sent, shifts, gap, withheld, stall_left, cyc, extra_lows;
    logic         finished, mid_pulsed, tv_early, ready_late, withhold;
    string        tag;
    tag = $sformatf("v%0d", k);
    exp_tab = '0;
    for (int i = 0; i < 32; i++) begin
      bytes[i] = v.rand_data ? 8'($urandom) : v.first_byte - 8'(i) * v.step;
      exp_tab  = {exp_tab[247:0], bytes[i]};
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output({tag, "_busy_after_start"}, busy, 1'b1);
    check_output({tag, "_valid_after_start"}, table_valid, 1'b0);

    lut_m = '0; sent = 0; shifts = 0; gap = 0; withheld = 0; stall_left = 0; cyc = 0;
    finished = 1'b0; mid_pulsed = 1'b0; tv_early = 1'b0; ready_late = 1'b0;
    while (!finished && cyc < 2000) begin
      if (!lut_cs_n) begin
        lut_m = {lut_m[254:0], lut_d};
        shifts++;
      end else if (shifts > 0 && shifts < TABLE_BITS) begin
        gap++;
      end
      if (table_valid) tv_early = 1'b1;
      if (sent == 32 && byte_ready) ready_late = 1'b1;
      if (v.abort_at > 0 && shifts == v.abort_at) begin
        abort = 1'b1;
        finished = 1'b1;
      end else if (v.reset_at > 0 && shifts == v.reset_at) begin
        finished = 1'b1;
      end else if (shifts == TABLE_BITS) begin
        finished = 1'b1;
      end else begin
        withhold = 1'b0;
        if (sent < 32 && byte_ready) begin
          if (stall_left > 0) begin
            withhold = 1'b1;
            stall_left--;
          end else if (v.rand_stall && sent > 0 && $urandom_range(0, 3) == 0) begin
            withhold = 1'b1;
          end
        end
        if (withhold && sent > 0) withheld++;
        byte_valid = !withhold && (sent < 32 || v.extra_byte);
        byte_data  = (sent < 32) ? bytes[sent] : 8'hA5;
        if (byte_valid && byte_ready && sent < 32) begin
          sent++;
          if (sent == v.stall_after + 1) stall_left = v.stall_len;
        end
        start = v.start_mid && !mid_pulsed && shifts == 50;
        if (start) mid_pulsed = 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;

    if (!finished) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got %0d shifts in %0d cycles, required %0d", tag, shifts, cyc, v.exp_shifts);
      byte_valid = 1'b0;
    end else if (v.abort_at > 0) begin
      @(negedge clk);
      abort = 1'b0;
      byte_valid = 1'b0;
      check_output({tag, "_abort_cs_n"}, lut_cs_n, 1'b1);
      check_output({tag, "_abort_busy"}, busy, 1'b0);
      check_output({tag, "_abort_valid"}, table_valid, 1'b0);
      @(negedge clk);
      check_idle_pins({tag, "_abort_idle"});
    end else if (v.reset_at > 0) begin
      #1 rst_n = 1'b0;
      #1;
      check_output({tag, "_rst_cs_n"}, lut_cs_n, 1'b1);
      check_output({tag, "_rst_d"}, lut_d, 1'b0);
      check_output({tag, "_rst_ready"}, byte_ready, 1'b0);
      check_output({tag, "_rst_busy"}, busy, 1'b0);
      check_output({tag, "_rst_valid"}, table_valid, 1'b0);
      byte_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_pins({tag, "_post_rst"});
    end else begin
      check_output({tag, "_valid_early"}, tv_early, 1'b0);
      @(negedge clk);
      check_output({tag, "_valid_after"}, table_valid, 1'b1);
      check_output({tag, "_busy_after"}, busy, 1'b0);
      extra_lows = 0;
      for (int i = 0; i < 4; i++) begin
        if (!lut_cs_n) extra_lows++;
        if (byte_ready) ready_late = 1'b1;
        @(negedge clk);
      end
      byte_valid = 1'b0;
      check_output({tag, "_shift_total"}, shifts + extra_lows, v.exp_shifts);
      check_output({tag, "_ready_after_32"}, ready_late, 1'b0);
      check_output({tag, "_table"}, lut_m, exp_tab);
      check_output({tag, "_entry15"}, lut_m[255:252], bytes[0][7:4]);
      check_output({tag, "_entry0"}, lut_m[3:0], bytes[31][3:0]);
      check_output({tag, "_stall_gap"}, gap, withheld);
    end
  endtask

  initial begin
    //          rand  first  step   st_af st_ln rstl  smid  extra abort reset exp
    vecs[0] = '{1'b0, 8'hFE, 8'h22, -1,   0,    1'b0, 1'b0, 1'b0, 0,    0,    256};
    vecs[1] = '{1'b0, 8'hFE, 8'h22, 3,    5,    1'b0, 1'b0, 1'b0, 0,    0,    256};
    vecs[2] = '{1'b1, 8'h00, 8'h00, -1,   0,    1'b0, 1'b0, 1'b0, 100,  0,    100};
    vecs[3] = '{1'b1, 8'h00, 8'h00, -1,   0,    1'b1, 1'b0, 1'b0, 0,    0,    256};
    vecs[4] = '{1'b0, 8'hFE, 8'h22, -1,   0,    1'b0, 1'b1, 1'b1, 0,    0,    256};
    vecs[5] = '{1'b1, 8'h00, 8'h00, -1,   0,    1'b0, 1'b0, 1'b0, 0,    57,   57};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 10,   3,    1'b1, 1'b0, 1'b1, 0,    0,    256};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = '0;
    #12;
    check_output("reset_cs_n", lut_cs_n, 1'b1);
    check_output("reset_d", lut_d, 1'b0);
    check_output("reset_ready", byte_ready, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_valid", table_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // A byte offered while idle must not be taken.
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    @(negedge clk);
    check_idle_pins("idle_byte");
    byte_valid = 1'b0;

    for (int k = 0; k < 7; k++) apply_stimulus(k, vecs[k]);

    // Make table_valid high first so the same-cycle start/abort has something to clear.
    apply_stimulus(7, vecs[0]);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_idle_pins("start_abort");
    check_output("start_abort_valid", table_valid, 1'b0);
    @(negedge clk);
    check_idle_pins("start_abort_later");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
